// File: rtl/axi_lite_to_axi_upsizer.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_to_axi_upsizer
// Description : AXI4-Lite slave to AXI4 master bridge with data upsizing.
//               Write data is replicated across the wide bus and strobes are
//               steered into the addressed lane; AW and W are joined so the
//               master side never sees W without its address. Outstanding
//               reads record their lane in a small FIFO so R data is taken
//               from the correct lane. Defining AXI_LITE_TO_AXI_WR_LIMIT_EN
//               adds a counter that limits outstanding writes to MaxWrites.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_to_axi_upsizer #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned LiteDataWidth = 32,
  parameter int unsigned AxiDataWidth  = 64,
  parameter int unsigned IdWidth       = 4,
  parameter int unsigned AxiId         = 0,
  parameter int unsigned MaxReads      = 4,
  parameter int unsigned MaxWrites     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  // AXI4-Lite slave side
  input  logic [AddrWidth-1:0]         slv_aw_addr_i,
  input  logic [2:0]                   slv_aw_prot_i,
  input  logic                         slv_aw_valid_i,
  output logic                         slv_aw_ready_o,
  input  logic [LiteDataWidth-1:0]     slv_w_data_i,
  input  logic [LiteDataWidth/8-1:0]   slv_w_strb_i,
  input  logic                         slv_w_valid_i,
  output logic                         slv_w_ready_o,
  output logic [1:0]                   slv_b_resp_o,
  output logic                         slv_b_valid_o,
  input  logic                         slv_b_ready_i,
  input  logic [AddrWidth-1:0]         slv_ar_addr_i,
  input  logic [2:0]                   slv_ar_prot_i,
  input  logic                         slv_ar_valid_i,
  output logic                         slv_ar_ready_o,
  output logic [LiteDataWidth-1:0]     slv_r_data_o,
  output logic [1:0]                   slv_r_resp_o,
  output logic                         slv_r_valid_o,
  input  logic                         slv_r_ready_i,
  // AXI4 master side
  output logic [IdWidth-1:0]           mst_aw_id_o,
  output logic [AddrWidth-1:0]         mst_aw_addr_o,
  output logic [7:0]                   mst_aw_len_o,
  output logic [2:0]                   mst_aw_size_o,
  output logic [1:0]                   mst_aw_burst_o,
  output logic                         mst_aw_lock_o,
  output logic [3:0]                   mst_aw_cache_o,
  output logic [2:0]                   mst_aw_prot_o,
  output logic [3:0]                   mst_aw_qos_o,
  output logic [3:0]                   mst_aw_region_o,
  output logic [5:0]                   mst_aw_atop_o,
  output logic [0:0]                   mst_aw_user_o,
  output logic                         mst_aw_valid_o,
  input  logic                         mst_aw_ready_i,
  output logic [AxiDataWidth-1:0]      mst_w_data_o,
  output logic [AxiDataWidth/8-1:0]    mst_w_strb_o,
  output logic                         mst_w_last_o,
  output logic [0:0]                   mst_w_user_o,
  output logic                         mst_w_valid_o,
  input  logic                         mst_w_ready_i,
  input  logic [IdWidth-1:0]           mst_b_id_i,
  input  logic [1:0]                   mst_b_resp_i,
  input  logic                         mst_b_valid_i,
  output logic                         mst_b_ready_o,
  output logic [IdWidth-1:0]           mst_ar_id_o,
  output logic [AddrWidth-1:0]         mst_ar_addr_o,
  output logic [7:0]                   mst_ar_len_o,
  output logic [2:0]                   mst_ar_size_o,
  output logic [1:0]                   mst_ar_burst_o,
  output logic                         mst_ar_lock_o,
  output logic [3:0]                   mst_ar_cache_o,
  output logic [2:0]                   mst_ar_prot_o,
  output logic [3:0]                   mst_ar_qos_o,
  output logic [3:0]                   mst_ar_region_o,
  output logic [0:0]                   mst_ar_user_o,
  output logic                         mst_ar_valid_o,
  input  logic                         mst_ar_ready_i,
  input  logic [IdWidth-1:0]           mst_r_id_i,
  input  logic [AxiDataWidth-1:0]      mst_r_data_i,
  input  logic [1:0]                   mst_r_resp_i,
  input  logic                         mst_r_last_i,
  input  logic                         mst_r_valid_i,
  output logic                         mst_r_ready_o
);

  localparam int unsigned Ratio     = AxiDataWidth / LiteDataWidth;
  localparam int unsigned LiteStrbW = LiteDataWidth / 8;
  localparam int unsigned AxiStrbW  = AxiDataWidth / 8;
  localparam int unsigned LiteOffW  = $clog2(LiteStrbW);
  localparam int unsigned AxiOffW   = $clog2(AxiStrbW);
  localparam int unsigned LaneW     = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam int unsigned PtrW      = (MaxReads > 1) ? $clog2(MaxReads) : 1;
  localparam int unsigned CntW      = $clog2(MaxReads + 1);

  // --------------------------------------------------------------------------
  // Lane selection from the address
  // --------------------------------------------------------------------------
  logic [LaneW-1:0] aw_lane;
  logic [LaneW-1:0] ar_lane;

  if (Ratio > 1) begin : g_lane
    assign aw_lane = slv_aw_addr_i[AxiOffW-1:LiteOffW];
    assign ar_lane = slv_ar_addr_i[AxiOffW-1:LiteOffW];
  end else begin : g_lane_none
    assign aw_lane = '0;
    assign ar_lane = '0;
  end

  // --------------------------------------------------------------------------
  // Constant AXI4 request fields: single beat, Lite-sized, INCR
  // --------------------------------------------------------------------------
  assign mst_aw_id_o     = IdWidth'(AxiId);
  assign mst_aw_addr_o   = slv_aw_addr_i;
  assign mst_aw_len_o    = 8'd0;
  assign mst_aw_size_o   = 3'($clog2(LiteStrbW));
  assign mst_aw_burst_o  = 2'b01;
  assign mst_aw_lock_o   = 1'b0;
  assign mst_aw_cache_o  = 4'd0;
  assign mst_aw_prot_o   = slv_aw_prot_i;
  assign mst_aw_qos_o    = 4'd0;
  assign mst_aw_region_o = 4'd0;
  assign mst_aw_atop_o   = 6'd0;
  assign mst_aw_user_o   = 1'b0;

  assign mst_ar_id_o     = IdWidth'(AxiId);
  assign mst_ar_addr_o   = slv_ar_addr_i;
  assign mst_ar_len_o    = 8'd0;
  assign mst_ar_size_o   = 3'($clog2(LiteStrbW));
  assign mst_ar_burst_o  = 2'b01;
  assign mst_ar_lock_o   = 1'b0;
  assign mst_ar_cache_o  = 4'd0;
  assign mst_ar_prot_o   = slv_ar_prot_i;
  assign mst_ar_qos_o    = 4'd0;
  assign mst_ar_region_o = 4'd0;
  assign mst_ar_user_o   = 1'b0;

  assign mst_w_data_o = {Ratio{slv_w_data_i}};
  assign mst_w_strb_o = AxiStrbW'(slv_w_strb_i) << (aw_lane * LiteStrbW);
  assign mst_w_last_o = 1'b1;
  assign mst_w_user_o = 1'b0;

  // --------------------------------------------------------------------------
  // Write join: AW and W are offered together and retired together
  // --------------------------------------------------------------------------
  logic wr_credit;
  logic wr_req;
  logic aw_hs;
  logic w_hs;
  logic wr_done;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;

  assign wr_req         = slv_aw_valid_i & slv_w_valid_i & wr_credit & ~rst_i;
  assign mst_aw_valid_o = wr_req & ~aw_done_q;
  assign mst_w_valid_o  = wr_req & ~w_done_q;
  assign aw_hs          = mst_aw_valid_o & mst_aw_ready_i;
  assign w_hs           = mst_w_valid_o & mst_w_ready_i;
  assign wr_done        = wr_req & (aw_done_q | aw_hs) & (w_done_q | w_hs);
  assign slv_aw_ready_o = wr_done;
  assign slv_w_ready_o  = wr_done;

  // Remember which half of the write has been accepted until both are
  always_comb begin
    aw_done_d = aw_done_q | aw_hs;
    w_done_d  = w_done_q | w_hs;
    if (wr_done) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end
  end

  // Write join flag registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // B channel is a straight passthrough
  assign slv_b_resp_o  = mst_b_resp_i;
  assign slv_b_valid_o = mst_b_valid_i & ~rst_i;
  assign mst_b_ready_o = slv_b_ready_i & ~rst_i;

`ifdef AXI_LITE_TO_AXI_WR_LIMIT_EN
  localparam int unsigned WrCntW = $clog2(MaxWrites + 1);

  logic [WrCntW-1:0] wr_cnt_q, wr_cnt_d;
  logic              b_hs;

  assign b_hs      = slv_b_valid_o & slv_b_ready_i;
  assign wr_credit = (wr_cnt_q < WrCntW'(MaxWrites));

  // Outstanding write count: up on completion, down on B
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (wr_done && !b_hs) begin
      wr_cnt_d = wr_cnt_q + WrCntW'(1);
    end else if (!wr_done && b_hs && (wr_cnt_q != '0)) begin
      wr_cnt_d = wr_cnt_q - WrCntW'(1);
    end
  end

  // Outstanding write counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
    end
  end
`else
  assign wr_credit = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Read path: lane offset FIFO
  // --------------------------------------------------------------------------
  logic [LaneW-1:0] lane_mem_q [MaxReads];
  logic [LaneW-1:0] lane_mem_d [MaxReads];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  rd_cnt_q, rd_cnt_d;
  logic             fifo_full;
  logic             fifo_empty;
  logic             ar_hs;
  logic             r_hs;
  logic             pop;
  logic [LaneW-1:0] r_lane;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxReads - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // A full FIFO blocks AR regardless of a same-cycle pop, keeping AR
  // readiness independent of the R channel.
  assign fifo_full      = (rd_cnt_q == CntW'(MaxReads));
  assign fifo_empty     = (rd_cnt_q == '0);
  assign mst_ar_valid_o = slv_ar_valid_i & ~fifo_full & ~rst_i;
  assign slv_ar_ready_o = mst_ar_ready_i & ~fifo_full & ~rst_i;
  assign ar_hs          = slv_ar_valid_i & slv_ar_ready_o;

  assign slv_r_valid_o  = mst_r_valid_i & ~rst_i;
  assign mst_r_ready_o  = slv_r_ready_i & ~rst_i;
  assign slv_r_resp_o   = mst_r_resp_i;
  assign r_hs           = slv_r_valid_o & slv_r_ready_i;
  assign pop            = r_hs & ~fifo_empty;
  assign r_lane         = fifo_empty ? '0 : lane_mem_q[rd_ptr_q];
  assign slv_r_data_o   = mst_r_data_i[r_lane * LiteDataWidth +: LiteDataWidth];

  // Push lane on AR handshake, pop on R handshake
  always_comb begin
    lane_mem_d = lane_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_cnt_d   = rd_cnt_q;
    if (ar_hs) begin
      lane_mem_d[wr_ptr_q] = ar_lane;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (ar_hs && !pop) begin
      rd_cnt_d = rd_cnt_q + CntW'(1);
    end else if (!ar_hs && pop) begin
      rd_cnt_d = rd_cnt_q - CntW'(1);
    end
  end

  // Read FIFO registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_mem_q <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_cnt_q   <= '0;
    end else begin
      lane_mem_q <= lane_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  // IDs and R last carry no information for single-beat fixed-ID traffic
  logic unused_inputs;
  assign unused_inputs = ^{mst_b_id_i, mst_r_id_i, mst_r_last_i};

`ifndef SYNTHESIS
  // An R beat with no read outstanding means the downstream broke protocol
  a_r_without_ar : assert property (@(posedge clk_i) disable iff (rst_i)
                                    mst_r_valid_i |-> !fifo_empty);
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_to_axi_upsizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_to_axi_upsizer
// Description : Directed bench for axi_lite_to_axi_upsizer. One instance with
//               a 2:1 width ratio and one with equal widths share the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_to_axi_upsizer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared stimulus
  logic [31:0] slv_aw_addr = '0, slv_ar_addr = '0, slv_w_data = '0;
  logic [2:0]  slv_aw_prot = '0, slv_ar_prot = '0;
  logic [3:0]  slv_w_strb = '0;
  logic        slv_aw_valid = 0, slv_w_valid = 0, slv_b_ready = 0;
  logic        slv_ar_valid = 0, slv_r_ready = 0;
  logic        mst_aw_ready = 0, mst_w_ready = 0, mst_ar_ready = 0;
  logic [1:0]  mst_b_resp = '0, mst_r_resp = '0;
  logic        mst_b_valid = 0, mst_r_valid = 0;
  logic [63:0] mst_r_data = '0;

  // wide instance outputs
  logic        slv_aw_ready, slv_w_ready, slv_b_valid, slv_ar_ready, slv_r_valid;
  logic [1:0]  slv_b_resp, slv_r_resp;
  logic [31:0] slv_r_data;
  logic [3:0]  mst_aw_id, mst_ar_id;
  logic [31:0] mst_aw_addr, mst_ar_addr;
  logic [7:0]  mst_aw_len, mst_ar_len;
  logic [2:0]  mst_aw_size, mst_ar_size, mst_aw_prot, mst_ar_prot;
  logic [1:0]  mst_aw_burst, mst_ar_burst;
  logic        mst_aw_lock, mst_ar_lock;
  logic [3:0]  mst_aw_cache, mst_ar_cache, mst_aw_qos, mst_ar_qos;
  logic [3:0]  mst_aw_region, mst_ar_region;
  logic [5:0]  mst_aw_atop;
  logic [0:0]  mst_aw_user, mst_ar_user, mst_w_user;
  logic        mst_aw_valid, mst_w_valid, mst_w_last, mst_b_ready, mst_ar_valid, mst_r_ready;
  logic [63:0] mst_w_data;
  logic [7:0]  mst_w_strb;

  // equal-width instance outputs
  logic        u1_slv_aw_ready, u1_slv_w_ready, u1_slv_b_valid, u1_slv_ar_ready, u1_slv_r_valid;
  logic [1:0]  u1_slv_b_resp, u1_slv_r_resp;
  logic [31:0] u1_slv_r_data;
  logic [3:0]  u1_mst_aw_id, u1_mst_ar_id;
  logic [31:0] u1_mst_aw_addr, u1_mst_ar_addr;
  logic [7:0]  u1_mst_aw_len, u1_mst_ar_len;
  logic [2:0]  u1_mst_aw_size, u1_mst_ar_size, u1_mst_aw_prot, u1_mst_ar_prot;
  logic [1:0]  u1_mst_aw_burst, u1_mst_ar_burst;
  logic        u1_mst_aw_lock, u1_mst_ar_lock;
  logic [3:0]  u1_mst_aw_cache, u1_mst_ar_cache, u1_mst_aw_qos, u1_mst_ar_qos;
  logic [3:0]  u1_mst_aw_region, u1_mst_ar_region;
  logic [5:0]  u1_mst_aw_atop;
  logic [0:0]  u1_mst_aw_user, u1_mst_ar_user, u1_mst_w_user;
  logic        u1_mst_aw_valid, u1_mst_w_valid, u1_mst_w_last, u1_mst_b_ready;
  logic        u1_mst_ar_valid, u1_mst_r_ready;
  logic [31:0] u1_mst_w_data;
  logic [3:0]  u1_mst_w_strb;

  axi_lite_to_axi_upsizer #(
    .AddrWidth(32), .LiteDataWidth(32), .AxiDataWidth(64), .IdWidth(4),
    .AxiId(0), .MaxReads(4), .MaxWrites(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_aw_addr_i(slv_aw_addr), .slv_aw_prot_i(slv_aw_prot), .slv_aw_valid_i(slv_aw_valid),
    .slv_aw_ready_o(slv_aw_ready),
    .slv_w_data_i(slv_w_data), .slv_w_strb_i(slv_w_strb), .slv_w_valid_i(slv_w_valid),
    .slv_w_ready_o(slv_w_ready),
    .slv_b_resp_o(slv_b_resp), .slv_b_valid_o(slv_b_valid), .slv_b_ready_i(slv_b_ready),
    .slv_ar_addr_i(slv_ar_addr), .slv_ar_prot_i(slv_ar_prot), .slv_ar_valid_i(slv_ar_valid),
    .slv_ar_ready_o(slv_ar_ready),
    .slv_r_data_o(slv_r_data), .slv_r_resp_o(slv_r_resp), .slv_r_valid_o(slv_r_valid),
    .slv_r_ready_i(slv_r_ready),
    .mst_aw_id_o(mst_aw_id), .mst_aw_addr_o(mst_aw_addr), .mst_aw_len_o(mst_aw_len),
    .mst_aw_size_o(mst_aw_size), .mst_aw_burst_o(mst_aw_burst), .mst_aw_lock_o(mst_aw_lock),
    .mst_aw_cache_o(mst_aw_cache), .mst_aw_prot_o(mst_aw_prot), .mst_aw_qos_o(mst_aw_qos),
    .mst_aw_region_o(mst_aw_region), .mst_aw_atop_o(mst_aw_atop), .mst_aw_user_o(mst_aw_user),
    .mst_aw_valid_o(mst_aw_valid), .mst_aw_ready_i(mst_aw_ready),
    .mst_w_data_o(mst_w_data), .mst_w_strb_o(mst_w_strb), .mst_w_last_o(mst_w_last),
    .mst_w_user_o(mst_w_user), .mst_w_valid_o(mst_w_valid), .mst_w_ready_i(mst_w_ready),
    .mst_b_id_i(4'd0), .mst_b_resp_i(mst_b_resp), .mst_b_valid_i(mst_b_valid),
    .mst_b_ready_o(mst_b_ready),
    .mst_ar_id_o(mst_ar_id), .mst_ar_addr_o(mst_ar_addr), .mst_ar_len_o(mst_ar_len),
    .mst_ar_size_o(mst_ar_size), .mst_ar_burst_o(mst_ar_burst), .mst_ar_lock_o(mst_ar_lock),
    .mst_ar_cache_o(mst_ar_cache), .mst_ar_prot_o(mst_ar_prot), .mst_ar_qos_o(mst_ar_qos),
    .mst_ar_region_o(mst_ar_region), .mst_ar_user_o(mst_ar_user),
    .mst_ar_valid_o(mst_ar_valid), .mst_ar_ready_i(mst_ar_ready),
    .mst_r_id_i(4'd0), .mst_r_data_i(mst_r_data), .mst_r_resp_i(mst_r_resp),
    .mst_r_last_i(1'b1), .mst_r_valid_i(mst_r_valid), .mst_r_ready_o(mst_r_ready)
  );

  axi_lite_to_axi_upsizer #(
    .AddrWidth(32), .LiteDataWidth(32), .AxiDataWidth(32), .IdWidth(4),
    .AxiId(0), .MaxReads(4), .MaxWrites(2)
  ) dut_r1 (
    .clk_i(clk), .rst_i(rst),
    .slv_aw_addr_i(slv_aw_addr), .slv_aw_prot_i(slv_aw_prot), .slv_aw_valid_i(slv_aw_valid),
    .slv_aw_ready_o(u1_slv_aw_ready),
    .slv_w_data_i(slv_w_data), .slv_w_strb_i(slv_w_strb), .slv_w_valid_i(slv_w_valid),
    .slv_w_ready_o(u1_slv_w_ready),
    .slv_b_resp_o(u1_slv_b_resp), .slv_b_valid_o(u1_slv_b_valid), .slv_b_ready_i(slv_b_ready),
    .slv_ar_addr_i(slv_ar_addr), .slv_ar_prot_i(slv_ar_prot), .slv_ar_valid_i(slv_ar_valid),
    .slv_ar_ready_o(u1_slv_ar_ready),
    .slv_r_data_o(u1_slv_r_data), .slv_r_resp_o(u1_slv_r_resp), .slv_r_valid_o(u1_slv_r_valid),
    .slv_r_ready_i(slv_r_ready),
    .mst_aw_id_o(u1_mst_aw_id), .mst_aw_addr_o(u1_mst_aw_addr), .mst_aw_len_o(u1_mst_aw_len),
    .mst_aw_size_o(u1_mst_aw_size), .mst_aw_burst_o(u1_mst_aw_burst),
    .mst_aw_lock_o(u1_mst_aw_lock), .mst_aw_cache_o(u1_mst_aw_cache),
    .mst_aw_prot_o(u1_mst_aw_prot), .mst_aw_qos_o(u1_mst_aw_qos),
    .mst_aw_region_o(u1_mst_aw_region), .mst_aw_atop_o(u1_mst_aw_atop),
    .mst_aw_user_o(u1_mst_aw_user), .mst_aw_valid_o(u1_mst_aw_valid),
    .mst_aw_ready_i(mst_aw_ready),
    .mst_w_data_o(u1_mst_w_data), .mst_w_strb_o(u1_mst_w_strb), .mst_w_last_o(u1_mst_w_last),
    .mst_w_user_o(u1_mst_w_user), .mst_w_valid_o(u1_mst_w_valid), .mst_w_ready_i(mst_w_ready),
    .mst_b_id_i(4'd0), .mst_b_resp_i(mst_b_resp), .mst_b_valid_i(mst_b_valid),
    .mst_b_ready_o(u1_mst_b_ready),
    .mst_ar_id_o(u1_mst_ar_id), .mst_ar_addr_o(u1_mst_ar_addr), .mst_ar_len_o(u1_mst_ar_len),
    .mst_ar_size_o(u1_mst_ar_size), .mst_ar_burst_o(u1_mst_ar_burst),
    .mst_ar_lock_o(u1_mst_ar_lock), .mst_ar_cache_o(u1_mst_ar_cache),
    .mst_ar_prot_o(u1_mst_ar_prot), .mst_ar_qos_o(u1_mst_ar_qos),
    .mst_ar_region_o(u1_mst_ar_region), .mst_ar_user_o(u1_mst_ar_user),
    .mst_ar_valid_o(u1_mst_ar_valid), .mst_ar_ready_i(mst_ar_ready),
    .mst_r_id_i(4'd0), .mst_r_data_i(mst_r_data[31:0]), .mst_r_resp_i(mst_r_resp),
    .mst_r_last_i(1'b1), .mst_r_valid_i(mst_r_valid), .mst_r_ready_o(u1_mst_r_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    slv_aw_valid = 0; slv_w_valid = 0; slv_b_ready = 0;
    slv_ar_valid = 0; slv_r_ready = 0;
    mst_aw_ready = 0; mst_w_ready = 0; mst_ar_ready = 0;
    mst_b_valid = 0; mst_r_valid = 0;
  endtask

  // Both master readies high: write completes in one cycle
  task automatic quick_write(input logic [31:0] addr, input string name);
    slv_aw_addr = addr; slv_w_data = 32'h0; slv_w_strb = 4'hF;
    slv_aw_valid = 1; slv_w_valid = 1; mst_aw_ready = 1; mst_w_ready = 1;
    #1;
    chk({name, "_slv_aw_ready"}, 64'(slv_aw_ready), 64'd1);
    step();
    idle();
  endtask

  task automatic return_b();
    mst_b_valid = 1; mst_b_resp = 2'b00; slv_b_ready = 1;
    step();
    idle();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wstrb;
  } wr_vec_t;

  wr_vec_t     wv [4];
  logic [31:0] rd_addr [5];
  logic [31:0] rd_exp  [5];
  int          pulses;

  initial begin
    wv[0] = '{32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 2'b00, 64'hDEADBEEF_DEADBEEF, 8'hF0};
    wv[1] = '{32'h0000_0000, 32'h1234_5678, 4'h3, 2'b00, 64'h12345678_12345678, 8'h03};
    wv[2] = '{32'h0000_000C, 32'hA5A5_5A5A, 4'h8, 2'b10, 64'hA5A55A5A_A5A55A5A, 8'h80};
    wv[3] = '{32'h0000_1000, 32'h0F0F_F0F0, 4'hF, 2'b01, 64'h0F0FF0F0_0F0FF0F0, 8'h0F};
    rd_addr[0] = 32'h0;  rd_exp[0] = 32'h3333_4444;
    rd_addr[1] = 32'h4;  rd_exp[1] = 32'h1111_2222;
    rd_addr[2] = 32'h8;  rd_exp[2] = 32'h3333_4444;
    rd_addr[3] = 32'hC;  rd_exp[3] = 32'h1111_2222;
    rd_addr[4] = 32'h10; rd_exp[4] = 32'h3333_4444;

    // ---------------- reset with every input requesting activity
    slv_aw_valid = 1; slv_w_valid = 1; slv_ar_valid = 1; slv_b_ready = 1; slv_r_ready = 1;
    mst_aw_ready = 1; mst_w_ready = 1; mst_ar_ready = 1; mst_b_valid = 1;
    step();
    step();
    chk("reset_handshakes",
        64'({mst_aw_valid, mst_w_valid, mst_ar_valid, slv_aw_ready, slv_w_ready,
             slv_ar_ready, slv_b_valid, slv_r_valid, mst_b_ready, mst_r_ready}), 64'd0);
    idle();
    rst = 0;
    step();

    // ---------------- table of single-cycle writes
    for (int i = 0; i < 4; i++) begin
      slv_aw_addr = wv[i].addr; slv_w_data = wv[i].data; slv_w_strb = wv[i].strb;
      slv_aw_prot = 3'(i + 1);
      slv_aw_valid = 1; slv_w_valid = 1; mst_aw_ready = 1; mst_w_ready = 1;
      #1;
      chk($sformatf("wr%0d_aw_valid", i), 64'(mst_aw_valid), 64'd1);
      chk($sformatf("wr%0d_w_valid", i), 64'(mst_w_valid), 64'd1);
      chk($sformatf("wr%0d_aw_addr", i), 64'(mst_aw_addr), 64'(wv[i].addr));
      chk($sformatf("wr%0d_aw_prot", i), 64'(mst_aw_prot), 64'(i + 1));
      chk($sformatf("wr%0d_w_data", i), mst_w_data, wv[i].exp_wdata);
      chk($sformatf("wr%0d_w_strb", i), 64'(mst_w_strb), 64'(wv[i].exp_wstrb));
      chk($sformatf("wr%0d_slv_ready", i), 64'({slv_aw_ready, slv_w_ready}), 64'd3);
      chk($sformatf("wr%0d_r1_w_data", i), 64'(u1_mst_w_data), 64'(wv[i].data));
      chk($sformatf("wr%0d_r1_w_strb", i), 64'(u1_mst_w_strb), 64'(wv[i].strb));
      if (i == 0) begin
        chk("wr_const_fields",
            64'({mst_aw_id, mst_aw_len, mst_aw_size, mst_aw_burst, mst_w_last, mst_aw_lock,
                 mst_aw_cache, mst_aw_atop}),
            64'({4'd0, 8'd0, 3'd2, 2'b01, 1'b1, 1'b0, 4'd0, 6'd0}));
      end
      step();
      idle();
      mst_b_valid = 1; mst_b_resp = wv[i].bresp; slv_b_ready = 1;
      #1;
      chk($sformatf("wr%0d_b", i), 64'({slv_b_valid, slv_b_resp, mst_b_ready}),
          64'({1'b1, wv[i].bresp, 1'b1}));
      step();
      idle();
    end

    // ---------------- AW accepted three cycles before W
    slv_aw_addr = 32'h8; slv_w_data = 32'h0BAD_F00D; slv_w_strb = 4'hF;
    slv_aw_valid = 1; slv_w_valid = 1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      mst_aw_ready = (c == 0);
      mst_w_ready  = (c == 3);
      #1;
      if (slv_aw_ready && slv_w_ready) pulses++;
      chk($sformatf("split%0d_aw_valid", c), 64'(mst_aw_valid), 64'(c == 0));
      chk($sformatf("split%0d_w_valid", c), 64'(mst_w_valid), 64'd1);
      chk($sformatf("split%0d_slv_ready", c), 64'({slv_aw_ready, slv_w_ready}),
          (c == 3) ? 64'd3 : 64'd0);
      step();
    end
    idle();
    chk("split_pulse_count", 64'(pulses), 64'd1);
    return_b();
    // flags must have cleared: a fresh write offers AW again
    slv_aw_valid = 1; slv_w_valid = 1;
    #1;
    chk("post_split_aw_valid", 64'(mst_aw_valid), 64'd1);
    step();
    idle();

    // ---------------- four reads fill the FIFO, fifth stalls
    mst_r_data = 64'h11112222_33334444;
    mst_ar_ready = 1;
    for (int i = 0; i < 4; i++) begin
      slv_ar_addr = rd_addr[i]; slv_ar_valid = 1;
      #1;
      chk($sformatf("ar%0d_ready", i), 64'({slv_ar_ready, mst_ar_valid}), 64'd3);
      chk($sformatf("ar%0d_addr", i), 64'(mst_ar_addr), 64'(rd_addr[i]));
      if (i == 0) chk("ar_const_fields", 64'({mst_ar_len, mst_ar_size, mst_ar_burst}),
                      64'({8'd0, 3'd2, 2'b01}));
      step();
    end
    slv_ar_addr = rd_addr[4];
    #1;
    chk("ar4_stalled", 64'({slv_ar_ready, mst_ar_valid}), 64'd0);
    step();
    mst_r_valid = 1; slv_r_ready = 1;
    for (int j = 0; j < 5; j++) begin
      mst_r_resp = 2'(j);
      #1;
      chk($sformatf("r%0d_data", j), 64'(slv_r_data), 64'(rd_exp[j]));
      chk($sformatf("r%0d_ctl", j), 64'({slv_r_valid, mst_r_ready, slv_r_resp}),
          64'({1'b1, 1'b1, 2'(j)}));
      if (j == 0) chk("ar4_full_with_pop", 64'(slv_ar_ready), 64'd0);
      if (j == 1) chk("ar4_released", 64'(slv_ar_ready), 64'd1);
      step();
      if (j == 1) slv_ar_valid = 0;
    end
    idle();

    // ---------------- reset with reads and a half-done write outstanding
    slv_ar_addr = 32'h0; slv_ar_valid = 1; mst_ar_ready = 1;
    slv_aw_addr = 32'h4; slv_aw_valid = 1; slv_w_valid = 1; mst_aw_ready = 1;
    step();
    mst_aw_ready = 0;
    slv_ar_addr = 32'h8;
    step();
    rst = 1;
    mst_aw_ready = 1; mst_w_ready = 1; mst_b_valid = 1; slv_b_ready = 1; slv_r_ready = 1;
    #1;
    chk("rst_mid_handshakes",
        64'({mst_aw_valid, mst_w_valid, mst_ar_valid, slv_aw_ready, slv_w_ready,
             slv_ar_ready, slv_b_valid, slv_r_valid, mst_b_ready, mst_r_ready}), 64'd0);
    step();
    idle();
    rst = 0;
    step();
    slv_aw_valid = 1; slv_w_valid = 1; mst_w_ready = 1;
    #1;
    chk("post_rst_aw_valid", 64'(mst_aw_valid), 64'd1);
    chk("post_rst_no_complete", 64'(slv_aw_ready), 64'd0);
    step();
    mst_w_ready = 0; mst_aw_ready = 1;
    #1;
    chk("post_rst_complete", 64'({slv_aw_ready, mst_w_valid}), 64'd2);
    step();
    idle();
    return_b();
    slv_ar_addr = 32'h4; slv_ar_valid = 1; mst_ar_ready = 1;
    #1;
    chk("post_rst_ar_ready", 64'(slv_ar_ready), 64'd1);
    step();
    idle();
    mst_r_data = 64'hAAAABBBB_CCCCDDDD; mst_r_valid = 1; slv_r_ready = 1; mst_r_resp = 2'b00;
    #1;
    chk("post_rst_r_lane1", 64'(slv_r_data), 64'h0000_0000_AAAA_BBBB);
    chk("r1_r_lane0", 64'(u1_slv_r_data), 64'h0000_0000_CCCC_DDDD);
    step();
    idle();

    // ---------------- outstanding write limit
    quick_write(32'h0, "lim_w0");
    quick_write(32'h4, "lim_w1");
    slv_aw_valid = 1; slv_w_valid = 1; mst_aw_ready = 1; mst_w_ready = 1;
`ifdef AXI_LITE_TO_AXI_WR_LIMIT_EN
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("lim_stall%0d", c), 64'({mst_aw_valid, mst_w_valid, slv_aw_ready}), 64'd0);
      step();
    end
    mst_b_valid = 1; slv_b_ready = 1;
    #1;
    chk("lim_stall_on_b", 64'(mst_aw_valid), 64'd0);
    step();
    mst_b_valid = 0; slv_b_ready = 0;
    #1;
    chk("lim_release", 64'({mst_aw_valid, slv_aw_ready}), 64'd3);
    step();
    idle();
    return_b();
    return_b();
`else
    #1;
    chk("nolim_third_write", 64'({mst_aw_valid, slv_aw_ready}), 64'd3);
    step();
    idle();
    return_b();
    return_b();
    return_b();
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_to_axi_upsizer.md
# axi_lite_to_axi_upsizer

Parametrised AXI4-Lite slave to AXI4 master bridge, successor to the fixed-width Lite-to-AXI adapter. Connects a narrow AXI4-Lite peripheral bus master to a wider AXI4 crossbar port. Steers write data and strobes into the addressed lane, and tracks outstanding reads so R data is extracted from the correct lane. Joins AW/W so the AXI side never sees W without its address, and optionally limits outstanding writes.

## Interface
- AddrWidth, 32: address width, both sides.
- LiteDataWidth, 32: AXI4-Lite data width; power of two, ≥8.
- AxiDataWidth, 64: AXI4 data width; power of two multiple of LiteDataWidth (ratio R = AxiDataWidth/LiteDataWidth, R=1 legal).
- IdWidth, 4: AXI4 ID width.
- AxiId, 0: constant ID driven on AW and AR.
- MaxReads, 4: read offset FIFO depth = max outstanding reads; ≥1.
- MaxWrites, 4: max outstanding writes (only with the configuration macro); ≥1.
- clk_i, in, 1: clock. All state on rising edge.
- rst_i, in, 1: synchronous, active-high reset.
- slv_aw_addr_i/prot_i/valid_i, in; slv_aw_ready_o, out: Lite AW channel.
- slv_w_data_i (LiteDataWidth), slv_w_strb_i (LiteDataWidth/8), slv_w_valid_i, in; slv_w_ready_o, out.
- slv_b_resp_o (2), slv_b_valid_o, out; slv_b_ready_i, in.
- slv_ar_addr_i/prot_i/valid_i, in; slv_ar_ready_o, out.
- slv_r_data_o (LiteDataWidth), slv_r_resp_o (2), slv_r_valid_o, out; slv_r_ready_i, in.
- mst_aw_* out (id, addr, len, size, burst, lock, cache, prot, qos, region, atop, user, valid); mst_aw_ready_i in.
- mst_w_data_o (AxiDataWidth), mst_w_strb_o (AxiDataWidth/8), mst_w_last_o, mst_w_user_o, mst_w_valid_o, out; mst_w_ready_i, in.
- mst_b_id_i, mst_b_resp_i, mst_b_valid_i, in; mst_b_ready_o, out.
- mst_ar_* out (same set as AW minus atop); mst_ar_ready_i in.
- mst_r_id_i, mst_r_data_i, mst_r_resp_i, mst_r_last_i, mst_r_valid_i, in; mst_r_ready_o, out.

## Operation
- Constant fields: id=AxiId, len=0, size=$clog2(LiteDataWidth/8), burst=INCR, cache/lock/qos/region/atop/user=0, w_last=1, prot from slave.
- Lane index L = addr[$clog2(AxiDataWidth/8)-1 : $clog2(LiteDataWidth/8)]; L=0 when R=1.
- Write join: request present when slv_aw_valid_i & slv_w_valid_i & write credit. Then mst_aw_valid_o = !aw_done, mst_w_valid_o = !w_done.
- mst_w_data_o = slv_w_data replicated R times; mst_w_strb_o = slv_w_strb << (L·LiteDataWidth/8).
- aw_done/w_done flags set on respective master handshake. slv_aw_ready_o and slv_w_ready_o assert together, in the cycle both are complete (done flag or handshake this cycle); flags clear that cycle.
- B: slv_b_* = mst_b_* directly; mst_b_ready_o = slv_b_ready_i.
- Read: mst_ar_valid_o = slv_ar_valid_i & !fifo_full; slv_ar_ready_o = mst_ar_ready_i & !fifo_full. AR handshake pushes L into offset FIFO.
- R: slv_r_data_o = lane [head] of mst_r_data_i; resp/valid/ready passed through. R handshake pops FIFO.
- Full FIFO blocks AR even if an R pop occurs the same cycle. Push and pop in the same cycle (not full) keep count.
- mst_r_valid_i with empty FIFO is a protocol violation: data lane 0, simulation assertion fires.

## Timing
- All channels zero-cycle combinational; no added latency.
- Write completion may take several cycles when mst AW and W ready in different cycles; slave-side ready pulses exactly once per write.
- While rst_i high: all *_valid_o and *_ready_o = 0, done flags = 0, FIFO empty, write counter = 0.
- Reset mid-transaction discards outstanding state; the environment is reset together.

## Configuration
- AXI_LITE_TO_AXI_WR_LIMIT_EN defined: counter (width $clog2(MaxWrites+1)) increments on write completion, decrements on B handshake. Simultaneous completion and B handshake leave it unchanged. Write credit = counter < MaxWrites.
- Undefined: no counter; write credit is always 1; MaxWrites ignored.

## Test plan
- R=2, Lite write addr 0x4, data 0xDEADBEEF, strb 0xF -> mst_w_data 0xDEADBEEF_DEADBEEF, strb 0xF0, size 2, len 0, last 1; B OKAY returned.
- Write with mst_aw_ready 3 cycles before mst_w_ready -> mst_aw_valid drops after AW handshake; single slv_aw_ready/slv_w_ready pulse in the W handshake cycle.
- 4 reads to 0x0, 0x4, 0x8, 0xC, R data 0x11112222_33334444 each -> slave sees 0x33334444, 0x11112222, 0x33334444, 0x11112222. A 5th AR is stalled until the first R handshake completes.
- WR_LIMIT_EN, MaxWrites=2, B held off -> third write stalls with mst_aw_valid=0. B handshake releases it next cycle.
- Reset asserted with 2 reads outstanding -> FIFO empty, all valids/readies 0; after release, a read to 0x4 returns lane 1.
- R=1 config (both widths 32) -> data, strb and lane passthrough unchanged.
